// File: rtl/switch_conditioner.sv
// Two-flop synchroniser, stability-count debounce and edge pulses
// for the timer's slide switches; every bit is independent.
module switch_conditioner #(
  parameter int N_SW            = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic            CLOCK_50,
  input  logic            Reset,
  input  logic [N_SW-1:0] SW_raw,
  output logic [N_SW-1:0] SW_clean,
  output logic [N_SW-1:0] SW_rise,
  output logic [N_SW-1:0] SW_fall
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             clean;
    logic             rise;
    logic             fall;

    // Synchronise, count consecutive disagreeing cycles, accept at the limit
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        cnt   <= '0;
        clean <= 1'b0;
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        s1   <= SW_raw[i];
        s2   <= s1;
        rise <= 1'b0;
        fall <= 1'b0;
        if (s2 == clean) begin
          cnt <= '0;
        end else if (cnt < LAST) begin
          cnt <= cnt + CNT_W'(1);
        end else begin
          cnt   <= '0;
          clean <= s2;
          rise  <= s2;
          fall  <= ~s2;
        end
      end
    end

    assign SW_clean[i] = clean;
    assign SW_rise[i]  = rise;
    assign SW_fall[i]  = fall;
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner: expected pulse events are
// queued by the stimulus and matched by an independent monitor.
module tb_switch_conditioner;

  localparam int N = 3;
  localparam int LAT = 6;

  logic         CLOCK_50;
  logic         Reset;
  logic [N-1:0] SW_raw;
  logic [N-1:0] SW_clean;
  logic [N-1:0] SW_rise;
  logic [N-1:0] SW_fall;

  typedef struct {
    logic [N-1:0] clean;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   failures;

  switch_conditioner #(
    .N_SW(N),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Reset(Reset),
    .SW_raw(SW_raw),
    .SW_clean(SW_clean),
    .SW_rise(SW_rise),
    .SW_fall(SW_fall)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Rising-edge counter used to time expected events
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [N-1:0] c, input logic [N-1:0] r,
                           input logic [N-1:0] f, input int at);
    exp_t e;
    e.clean = c;
    e.rise  = r;
    e.fall  = f;
    e.cyc   = at;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk({name, "_drained"}, q.size(), 0);
    repeat (4) @(negedge CLOCK_50);
  endtask

  // Monitor: any pulse must match the oldest queued expectation
  always @(negedge CLOCK_50) begin
    if (!Reset && (SW_rise | SW_fall) != '0) begin
      chk("rise_and_fall_same_bit", int'(SW_rise & SW_fall), 0);
      if (q.size() == 0) begin
        chk("unexpected_event", int'({SW_rise, SW_fall}), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ev_clean", int'(SW_clean), int'(e.clean));
        chk("ev_rise", int'(SW_rise), int'(e.rise));
        chk("ev_fall", int'(SW_fall), int'(e.fall));
        chk("ev_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int c;
    cyc      = 0;
    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    SW_raw   = 3'b111;

    // Reset with switches high
    repeat (3) @(negedge CLOCK_50);
    chk("rst_clean", int'(SW_clean), 0);
    chk("rst_rise", int'(SW_rise), 0);
    chk("rst_fall", int'(SW_fall), 0);
    Reset = 1'b0;
    c = cyc;
    expect_ev(3'b111, 3'b111, 3'b000, c + LAT);
    drain("post_reset_rise");
    chk("clean_after_reset", int'(SW_clean), 3'b111);

    // All switches released together
    @(negedge CLOCK_50);
    SW_raw = 3'b000;
    c = cyc;
    expect_ev(3'b000, 3'b000, 3'b111, c + LAT);
    drain("all_fall");

    // Clean step on bit 1
    @(negedge CLOCK_50);
    SW_raw = 3'b010;
    c = cyc;
    expect_ev(3'b010, 3'b010, 3'b000, c + LAT);
    drain("step_bit1");

    // Glitch of DEBOUNCE_CYCLES-1 cycles on bit 0
    @(negedge CLOCK_50);
    SW_raw[0] = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    SW_raw[0] = 1'b0;
    repeat (12) @(negedge CLOCK_50);
    chk("glitch_clean", int'(SW_clean), 3'b010);

    // Bounce on bit 2, then settle high
    for (int t = 0; t < 20; t++) begin
      @(negedge CLOCK_50);
      SW_raw[2] = ((t % 4) < 2);
    end
    @(negedge CLOCK_50);
    SW_raw[2] = 1'b1;
    c = cyc;
    expect_ev(3'b110, 3'b100, 3'b000, c + LAT);
    drain("bounce_bit2");

    // Get to clean = 100
    @(negedge CLOCK_50);
    SW_raw = 3'b100;
    c = cyc;
    expect_ev(3'b100, 3'b000, 3'b010, c + LAT);
    drain("fall_bit1");

    // Simultaneous 100 -> 001
    @(negedge CLOCK_50);
    SW_raw = 3'b001;
    c = cyc;
    expect_ev(3'b001, 3'b001, 3'b100, c + LAT);
    drain("simultaneous");

    // Reset mid-count on bit 1
    @(negedge CLOCK_50);
    SW_raw = 3'b011;
    repeat (4) @(posedge CLOCK_50);
    #2;
    chk("pre_midreset_clean", int'(SW_clean), 3'b001);
    Reset = 1'b1;
    #1;
    chk("midreset_clean", int'(SW_clean), 0);
    chk("midreset_rise", int'(SW_rise), 0);
    chk("midreset_fall", int'(SW_fall), 0);
    repeat (2) @(negedge CLOCK_50);
    Reset = 1'b0;
    c = cyc;
    expect_ev(3'b011, 3'b011, 3'b000, c + LAT);
    drain("midreset_recount");
    chk("final_clean", int'(SW_clean), 3'b011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
